// File: rtl/sram_like_pkg.sv
// Shared encodings for the data-side SRAM-like responder: access sizes, FSM states and the
// stall LFSR seed.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StAccess,
    StResp
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/sram_like_be_gen.sv
// Byte-enable generator: maps access size and the low address bits to SRAM byte lanes.
module sram_like_be_gen
  import sram_like_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] be
);

  always_comb begin
    be = 4'b1111;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      // Word and the illegal size 3 both cover the whole aligned word.
      default:   be = 4'b1111;
    endcase
  end

endmodule

// File: rtl/d_sram_like_to_sram.sv
// Data-side SRAM-like responder backed by a one-cycle synchronous SRAM, single outstanding access.
// Define SRAM_LIKE_RAND_STALL_EN to gate the idle address handshake with an 8-bit LFSR.
module d_sram_like_to_sram
  import sram_like_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [3:0] LatLoad = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       hold_q, hold_d;
  logic              latch_en;
  logic              idle_ok;
  logic [3:0]        be;

  // Upper address bits alias and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^data_addr[31:ADDR_W+2];

`ifdef SRAM_LIKE_RAND_STALL_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign idle_ok = lfsr_q[0];
`else
  assign idle_ok = 1'b1;
`endif

  sram_like_be_gen u_be_gen (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .be      (be)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    latch_en     = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = hold_q;
    ram_en       = 1'b0;
    ram_wen      = 4'b0000;
    unique case (state_q)
      StIdle: begin
        data_addr_ok = idle_ok;
        if (data_req && idle_ok) begin
          latch_en = 1'b1;
          if (LATENCY > 0) begin
            state_d = StDelay;
            cnt_d   = LatLoad;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StDelay: begin
        if (cnt_q == 4'd0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: begin
        ram_en  = 1'b1;
        ram_wen = wr_q ? be : 4'b0000;
        state_d = StResp;
      end
      StResp: begin
        data_data_ok = 1'b1;
        if (!wr_q) begin
          data_rdata = ram_rdata;
          hold_d     = ram_rdata;
        end
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      hold_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      if (latch_en) begin
        wr_q    <= data_wr;
        size_q  <= data_size;
        addr_q  <= data_addr[ADDR_W+1:0];
        wdata_q <= data_wdata;
      end
    end
  end

  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign ram_wdata = wdata_q;

endmodule
